axis_adc_average: RTL and testbench

Downstream consumer of the DDR ADC capture stage. Takes the free-running, sign-extended sample stream, sums N consecutive signed samples (boxcar decimation) and emits one sum per window on an AXI4-Stream master with full tvalid/tready handshake. The upstream stage has no backpressure, so a sum the master side cannot accept in time is dropped and counted, never stalls input.

---
 rtl/axis_adc_average.sv | 179 +++++++++++++++++
 tb/tb_axis_adc_average.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/axis_adc_average.sv
// ---------------------------------------------------------------------------
// axis_adc_average
//
// Boxcar decimator for the free-running ADC sample stream. Sums N consecutive
// signed samples and emits one full-width sum per window on an AXI4-Stream
// master. The input side never stalls: a finished sum that cannot be loaded
// into the output register (previous sum still waiting on tready) is dropped.
//
// Ports:
//   aclk           system clock, rising edge
//   areset         synchronous reset, active-high
//   cfg_data       decimation ratio N (unsigned), 0 = disabled
//   s_axis_tdata   signed ADC sample (already sign-extended upstream)
//   s_axis_tvalid  sample valid
//   s_axis_tready  always 1
//   m_axis_tdata   signed window sum
//   m_axis_tvalid  window sum valid
//   m_axis_tready  downstream ready
//   sts_data       dropped-sum counter (zero unless the macro below is set)
//
// Build option:
//   AXIS_ADC_AVERAGE_DROP_CNT_EN  enables the saturating 32-bit drop counter
//                                 on sts_data; otherwise sts_data is tied 0.
//
// ACC_WIDTH must be >= AXIS_TDATA_WIDTH + CNTR_WIDTH so a full window of
// extreme samples can never wrap the accumulator.
//
// State table:
//   state | meaning
//   IDLE  | cfg_data == 0 seen; samples ignored, waiting for a ratio
//   ACCUM | summing samples of the current window of N_q samples
// ---------------------------------------------------------------------------
module axis_adc_average #(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int CNTR_WIDTH       = 16,
    parameter int ACC_WIDTH        = 32
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [CNTR_WIDTH-1:0]       cfg_data,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [ACC_WIDTH-1:0]        m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [31:0]                 sts_data
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam logic [CNTR_WIDTH-1:0] CNT_ONE = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNTR_WIDTH-1:0] n_q, n_d;
    logic [ACC_WIDTH-1:0]  tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;

    logic [ACC_WIDTH-1:0]  sample_ext;
    logic [ACC_WIDTH-1:0]  win_sum;
    logic                  win_done;
    logic                  out_load;

    assign sample_ext = {{(ACC_WIDTH-AXIS_TDATA_WIDTH){s_axis_tdata[AXIS_TDATA_WIDTH-1]}},
                         s_axis_tdata};
    assign win_sum    = acc_q + sample_ext;

    // Window sequencing: accumulator, sample counter and latched ratio.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        win_done = 1'b0;

        case (state_q)
            IDLE: begin
                // The transition edge only latches N; any sample present
                // on this edge is not part of the new window.
                if (cfg_data != '0) begin
                    n_d     = cfg_data;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (s_axis_tvalid) begin
                    if (cnt_q == n_q - CNT_ONE) begin
                        win_done = 1'b1;
                        acc_d    = '0;
                        cnt_d    = '0;
                        // Ratio changes take effect only at window boundaries.
                        n_d      = cfg_data;
                        if (cfg_data == '0) begin
                            state_d = IDLE;
                        end
                    end else begin
                        acc_d = win_sum;
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register: a new sum may load when the register is empty or is
    // being emptied on this same edge; otherwise the new sum is lost.
    always_comb begin
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        out_load = win_done && (!tvalid_q || m_axis_tready);

        if (out_load) begin
            tdata_d  = win_sum;
            tvalid_d = 1'b1;
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            n_q      <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
        end
    end

`ifdef AXIS_ADC_AVERAGE_DROP_CNT_EN
    logic [31:0] drop_cnt_q, drop_cnt_d;
    logic        drop;

    assign drop = win_done && !out_load;

    // Saturating so a long-stalled consumer never sees the count wrap to 0.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 32'hFFFF_FFFF)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign sts_data = drop_cnt_q;
`else
    assign sts_data = 32'd0;
`endif

    assign s_axis_tready = 1'b1;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_axis_adc_average.sv
module tb_axis_adc_average;

    logic        aclk = 1'b0;
    logic        areset;
    logic [15:0] cfg_data;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] sts_data;

    int n_vec = 0;
    int n_err = 0;

`ifdef AXIS_ADC_AVERAGE_DROP_CNT_EN
    localparam logic [31:0] EXP_DROPS = 32'd2;
`else
    localparam logic [31:0] EXP_DROPS = 32'd0;
`endif

    axis_adc_average #(
        .AXIS_TDATA_WIDTH(16),
        .CNTR_WIDTH      (16),
        .ACC_WIDTH       (32)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .cfg_data     (cfg_data),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .sts_data     (sts_data)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic        vld;
        logic [15:0] dat;
        logic        rdy;
        logic [15:0] cfg;
        logic        e_vld;
        logic [31:0] e_dat;
    } vec_t;

    vec_t tbl[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs, clock once, sample 1 ns after the edge.
    task automatic step(input logic vld, input logic [15:0] dat);
        s_axis_tvalid = vld;
        s_axis_tdata  = dat;
        @(posedge aclk);
        #1;
    endtask

    task automatic check_out(input string name, input logic e_vld, input logic [31:0] e_dat);
        check({name, ".tvalid"}, {31'd0, m_axis_tvalid}, {31'd0, e_vld});
        check({name, ".tdata"}, m_axis_tdata, e_dat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{1'b0, 16'h0000, 1'b1, 16'd4, 1'b0, 32'd0};
        tbl[1]  = '{1'b1, 16'h0001, 1'b1, 16'd4, 1'b0, 32'd0};
        tbl[2]  = '{1'b1, 16'h0002, 1'b1, 16'd4, 1'b0, 32'd0};
        tbl[3]  = '{1'b1, 16'h0003, 1'b1, 16'd4, 1'b0, 32'd0};
        tbl[4]  = '{1'b1, 16'h0004, 1'b1, 16'd4, 1'b1, 32'd10};
        tbl[5]  = '{1'b1, 16'hFFF6, 1'b1, 16'd4, 1'b0, 32'd10};
        tbl[6]  = '{1'b1, 16'hFFEC, 1'b1, 16'd4, 1'b0, 32'd10};
        tbl[7]  = '{1'b1, 16'hFFE2, 1'b1, 16'd4, 1'b0, 32'd10};
        // cfg moves to 1 during the last sample: relatched at window end.
        tbl[8]  = '{1'b1, 16'hFFD8, 1'b1, 16'd1, 1'b1, 32'hFFFF_FF9C};
        tbl[9]  = '{1'b1, 16'h7FFF, 1'b1, 16'd1, 1'b1, 32'h0000_7FFF};
        tbl[10] = '{1'b1, 16'h8000, 1'b1, 16'd1, 1'b1, 32'hFFFF_8000};
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 16'd1, 1'b0, 32'hFFFF_8000};
        tbl[12] = '{1'b1, 16'h0000, 1'b1, 16'd0, 1'b1, 32'd0};
        // IDLE -> ACCUM edge: the sample 9 must not be summed.
        tbl[13] = '{1'b1, 16'h0009, 1'b1, 16'd3, 1'b0, 32'd0};
        tbl[14] = '{1'b1, 16'h0005, 1'b1, 16'd3, 1'b0, 32'd0};
        tbl[15] = '{1'b0, 16'h0005, 1'b1, 16'd3, 1'b0, 32'd0};
        tbl[16] = '{1'b1, 16'h0005, 1'b1, 16'd3, 1'b0, 32'd0};
        tbl[17] = '{1'b0, 16'h0005, 1'b1, 16'd3, 1'b0, 32'd0};
        tbl[18] = '{1'b1, 16'h0005, 1'b1, 16'd3, 1'b1, 32'd15};
        tbl[19] = '{1'b0, 16'h0000, 1'b0, 16'd3, 1'b1, 32'd15};
        tbl[20] = '{1'b0, 16'h0000, 1'b1, 16'd3, 1'b0, 32'd15};

        areset        = 1'b1;
        cfg_data      = 16'd0;
        s_axis_tdata  = 16'd0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        step(1'b0, 16'd0);
        step(1'b0, 16'd0);
        check("reset.tready", {31'd0, s_axis_tready}, 32'd1);
        check_out("reset", 1'b0, 32'd0);
        check("reset.sts", sts_data, 32'd0);
        areset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            cfg_data      = tbl[i].cfg;
            m_axis_tready = tbl[i].rdy;
            step(tbl[i].vld, tbl[i].dat);
            check_out($sformatf("tbl[%0d]", i), tbl[i].e_vld, tbl[i].e_dat);
        end

        // Backpressure: N=2, tready low, sums 2 kept, 4 and 6 dropped.
        areset = 1'b1;
        step(1'b0, 16'd0);
        areset        = 1'b0;
        cfg_data      = 16'd2;
        m_axis_tready = 1'b0;
        step(1'b0, 16'd0);
        step(1'b1, 16'd1);
        step(1'b1, 16'd1);
        check_out("bp.first", 1'b1, 32'd2);
        step(1'b1, 16'd2);
        step(1'b1, 16'd2);
        step(1'b1, 16'd3);
        step(1'b1, 16'd3);
        check_out("bp.held", 1'b1, 32'd2);
        check("bp.sts", sts_data, EXP_DROPS);
        m_axis_tready = 1'b1;
        step(1'b0, 16'd0);
        check_out("bp.release", 1'b0, 32'd2);
        check("bp.sts_after", sts_data, EXP_DROPS);

        // Reset mid-window with a sum pending (N=2 still active).
        m_axis_tready = 1'b0;
        step(1'b1, 16'd7);
        step(1'b1, 16'd8);
        check_out("rst.pending", 1'b1, 32'd15);
        step(1'b1, 16'd1);
        areset = 1'b1;
        step(1'b1, 16'd50);
        check_out("rst.cleared", 1'b0, 32'd0);
        check("rst.sts", sts_data, 32'd0);
        check("rst.tready", {31'd0, s_axis_tready}, 32'd1);
        areset        = 1'b0;
        cfg_data      = 16'd4;
        m_axis_tready = 1'b1;
        step(1'b0, 16'd0);
        step(1'b1, 16'd2);
        step(1'b1, 16'd2);
        step(1'b1, 16'd2);
        check_out("rst.partial", 1'b0, 32'd0);
        step(1'b1, 16'd2);
        check_out("rst.sum", 1'b1, 32'd8);

        // cfg to 0 mid-window: window completes, then samples ignored.
        step(1'b0, 16'd0);
        check_out("cfg0.drain", 1'b0, 32'd8);
        step(1'b1, 16'd1);
        step(1'b1, 16'd2);
        cfg_data = 16'd0;
        step(1'b1, 16'd3);
        check_out("cfg0.mid", 1'b0, 32'd8);
        step(1'b1, 16'd4);
        check_out("cfg0.sum", 1'b1, 32'd10);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'd7);
            check_out($sformatf("cfg0.idle[%0d]", i), 1'b0, 32'd10);
        end
        cfg_data = 16'd2;
        step(1'b1, 16'd100);
        step(1'b1, 16'd3);
        check_out("cfg0.restart", 1'b0, 32'd10);
        step(1'b1, 16'd4);
        check_out("cfg0.newsum", 1'b1, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
